// File: rtl/tank_pump_sequencer_pkg.sv
// Shared types for the tank pump sequencer: FSM state and fault code encodings.
package tank_pump_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE   = 2'b00,
        FC_SENSOR = 2'b01,
        FC_DRYRUN = 2'b10
    } fault_code_t;

    localparam logic PUMP_A = 1'b0;
    localparam logic PUMP_B = 1'b1;

    // High water seen without low water: a sensor must be lying.
    function automatic logic sensors_inconsistent(input logic i_db, input logic s_db);
        return !i_db && s_db;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a hold counter; db follows raw only after
// the synchronised value has differed from db for DEB_CYCLES consecutive cycles.
module sensor_debounce #(
    parameter int   DEB_CYCLES = 4,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    // Synchroniser resets to the debounced reset value so release causes no spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            db    <= RST_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tank_pump_sequencer.sv
// Two-pump tank fill sequencer: debounced level sensors drive a Moore FSM with
// hysteresis, pump alternation, minimum run time and a dry-run timeout.
module tank_pump_sequencer
    import tank_pump_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int MIN_RUN    = 16,
    parameter int MAX_RUN    = 1000,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       I,
    input  logic       S,
    input  logic       enable,
    input  logic       fault_clr,
    output logic       pump_a,
    output logic       pump_b,
    output logic       busy,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN - 1);
    localparam logic [CNT_W-1:0] RUN_SAT  = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_RUN - 1);
    // bit 0 = lower sensor I (resets wet), bit 1 = upper sensor S (resets dry)
    localparam logic [1:0] DB_RST = 2'b01;

    logic [1:0] raw, db;
    logic       i_db, s_db, incons;

    assign raw = {S, I};

    for (genvar g = 0; g < 2; g++) begin : g_deb
        sensor_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .RST_VAL   (DB_RST[g])
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[g]),
            .db   (db[g])
        );
    end

    assign i_db   = db[0];
    assign s_db   = db[1];
    assign incons = sensors_inconsistent(i_db, s_db);

    state_t           state, state_n;
    fault_code_t      code, code_n;
    logic             sel, sel_n;
    logic             last_pump, last_n;
    logic [CNT_W-1:0] run_cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            code      <= FC_NONE;
            sel       <= PUMP_A;
            last_pump <= PUMP_B;
            run_cnt   <= '0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            sel       <= sel_n;
            last_pump <= last_n;
            run_cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code;
        sel_n   = sel;
        last_n  = last_pump;
        cnt_n   = run_cnt;
        case (state)
            ST_IDLE: begin
                if (incons) begin
                    state_n = ST_FAULT;
                    code_n  = FC_SENSOR;
                end else if (enable && !i_db) begin
                    state_n = ST_FILL;
                    sel_n   = ~last_pump;
                    cnt_n   = '0;
                end
            end
            ST_FILL: begin
                if (incons) begin
                    state_n = ST_FAULT;
                    code_n  = FC_SENSOR;
                end else if (run_cnt == RUN_LAST && !s_db) begin
                    state_n = ST_FAULT;
                    code_n  = FC_DRYRUN;
                end else if (!enable) begin
                    state_n = ST_IDLE;
                end else if (s_db && run_cnt >= MIN_LAST) begin
                    state_n = ST_IDLE;
                end else if (run_cnt != RUN_SAT) begin
                    cnt_n = run_cnt + 1'b1;
                end
                // Every way out of a fill, aborted or not, hands the next cycle to the other pump.
                if (state_n != ST_FILL) last_n = sel;
            end
            ST_FAULT: begin
                if (fault_clr && !incons) begin
                    state_n = ST_IDLE;
                    code_n  = FC_NONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                code_n  = FC_NONE;
            end
        endcase
    end

    assign pump_a     = (state == ST_FILL) && (sel == PUMP_A);
    assign pump_b     = (state == ST_FILL) && (sel == PUMP_B);
    assign busy       = (state == ST_FILL);
    assign fault      = (state == ST_FAULT);
    assign fault_code = code;

endmodule

// File: tb/tb_tank_pump_sequencer.sv
// Scenario tasks with timing expectations taken from the sensor/FSM rules, then
// a randomized run compared every cycle against a behavioural model.
module tb_tank_pump_sequencer;

    localparam int DEB = 4;
    localparam int MIN = 16;
    localparam int MAX = 64;

    logic       clk = 1'b0;
    logic       reset, I, S, enable, fault_clr;
    logic       pump_a, pump_b, busy, fault;
    logic [1:0] fault_code;

    int n_checks = 0;
    int n_pass   = 0;

    tank_pump_sequencer #(
        .DEB_CYCLES(DEB), .MIN_RUN(MIN), .MAX_RUN(MAX), .CNT_W(7)
    ) dut (
        .clk(clk), .reset(reset), .I(I), .S(S), .enable(enable), .fault_clr(fault_clr),
        .pump_a(pump_a), .pump_b(pump_b), .busy(busy), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit       q_i[$], q_s[$];     // raw samples, one per clock edge
    bit       m_idb, m_sdb;
    bit       m_filling, m_faulted, m_pump, m_next;
    int       m_elapsed;
    logic [1:0] m_code;

    // Debounced value flips once the sample seen through the 2-flop delay has
    // disagreed with it for DEB consecutive edges.
    function automatic bit deb_next(input bit q[$], input bit db);
        int  n;
        bit  all_diff;
        n = q.size();
        if (n - 2 - DEB < 0) return db;
        all_diff = 1'b1;
        for (int k = n - 2 - DEB; k <= n - 3; k++)
            if (q[k] == db) all_diff = 1'b0;
        return all_diff ? ~db : db;
    endfunction

    task automatic model_step();
        bit incons, stop;
        if (reset) begin
            m_filling = 0; m_faulted = 0; m_code = 2'b00;
            m_next = 0; m_pump = 0; m_elapsed = 0;
            m_idb = 1; m_sdb = 0;
            q_i = '{1'b1, 1'b1};
            q_s = '{1'b0, 1'b0};
        end else begin
            incons = !m_idb && m_sdb;
            if (m_faulted) begin
                if (fault_clr && !incons) begin
                    m_faulted = 0;
                    m_code = 2'b00;
                end
            end else if (m_filling) begin
                stop = 1;
                if (incons) begin
                    m_faulted = 1; m_code = 2'b01;
                end else if (m_elapsed == MAX - 1 && !m_sdb) begin
                    m_faulted = 1; m_code = 2'b10;
                end else if (!enable) begin
                    stop = 1;
                end else if (m_sdb && m_elapsed >= MIN - 1) begin
                    stop = 1;
                end else begin
                    stop = 0;
                    if (m_elapsed < MAX) m_elapsed++;
                end
                if (stop) begin
                    m_filling = 0;
                    m_next = !m_pump;
                end
            end else begin
                if (incons) begin
                    m_faulted = 1; m_code = 2'b01;
                end else if (enable && !m_idb) begin
                    m_filling = 1; m_pump = m_next; m_elapsed = 0;
                end
            end
            q_i.push_back(I);
            q_s.push_back(S);
            m_idb = deb_next(q_i, m_idb);
            m_sdb = deb_next(q_s, m_sdb);
            while (q_i.size() > DEB + 4) void'(q_i.pop_front());
            while (q_s.size() > DEB + 4) void'(q_s.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Ends any running fill cleanly (tank full) and returns sensors to mid-level.
    task automatic finish_fill();
        I = 1; S = 1; ticks(30);
        S = 0; ticks(8);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; I = 1; S = 0; enable = 0; fault_clr = 0;
        ticks(2);
        n_checks++;
        if ({pump_a, pump_b, busy, fault, fault_code} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000", {pump_a, pump_b, busy, fault, fault_code});
        else n_pass++;
        reset = 0; ticks(3);
        n_checks++;
        if ({pump_a, pump_b, busy, fault, fault_code} !== 6'b0)
            $display("FAIL idle_after_reset: got %b want 000000", {pump_a, pump_b, busy, fault, fault_code});
        else n_pass++;
    endtask

    task automatic test_fill_alternate();
        bit ok;
        enable = 1; I = 1; S = 0; ticks(8);
        I = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (pump_a !== (k == 7) || pump_b !== 1'b0 || busy !== (k == 7))
                $display("FAIL fill_start_a cycle %0d: a=%b b=%b busy=%b want a=%b b=0", k, pump_a, pump_b, busy, k == 7);
            else n_pass++;
        end
        ok = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (pump_a !== 1'b1) ok = 0;
        end
        n_checks++;
        if (!ok) $display("FAIL fill_hold_a: pump_a dropped during 30-cycle hold, want 1");
        else n_pass++;
        I = 1; S = 1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (pump_a !== (k < 7))
                $display("FAIL fill_stop_a cycle %0d: a=%b want %b", k, pump_a, k < 7);
            else n_pass++;
        end
        S = 0; ticks(8);
        I = 0; ticks(7);
        n_checks++;
        if (pump_b !== 1'b1 || pump_a !== 1'b0)
            $display("FAIL alternate_b: a=%b b=%b want a=0 b=1", pump_a, pump_b);
        else n_pass++;
        finish_fill();
    endtask

    task automatic test_glitch();
        bit ok;
        I = 0; ticks(3);
        I = 1;
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pump_a | pump_b | busy) ok = 0;
        end
        n_checks++;
        if (!ok) $display("FAIL glitch_ignored: a pump ran after a 3-cycle I pulse, want none");
        else n_pass++;
    endtask

    task automatic test_min_run();
        bit ok;
        I = 0; ticks(6);
        n_checks++;
        if (pump_a !== 1'b0) $display("FAIL min_run_pre: a=%b want 0", pump_a);
        else n_pass++;
        I = 1; S = 1;
        tick();
        n_checks++;
        if (pump_a !== 1'b1) $display("FAIL min_run_start: a=%b want 1", pump_a);
        else n_pass++;
        ok = 1;
        for (int k = 0; k < MIN - 1; k++) begin
            tick();
            if (pump_a !== 1'b1) ok = 0;
        end
        n_checks++;
        if (!ok) $display("FAIL min_run_hold: pump_a dropped before %0d cycles, want held", MIN);
        else n_pass++;
        tick();
        n_checks++;
        if (pump_a !== 1'b0 || busy !== 1'b0) $display("FAIL min_run_end: a=%b busy=%b want 0 0", pump_a, busy);
        else n_pass++;
        S = 0; ticks(8);
    endtask

    task automatic test_dry_run();
        I = 0; ticks(7);
        n_checks++;
        if (pump_b !== 1'b1) $display("FAIL dry_run_start_b: b=%b want 1", pump_b);
        else n_pass++;
        ticks(MAX - 1);
        n_checks++;
        if (pump_b !== 1'b1 || fault !== 1'b0) $display("FAIL dry_run_before: b=%b fault=%b want 1 0", pump_b, fault);
        else n_pass++;
        tick();
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10 || pump_a !== 1'b0 || pump_b !== 1'b0)
            $display("FAIL dry_run_fault: fault=%b code=%b a=%b b=%b want 1 10 0 0", fault, fault_code, pump_a, pump_b);
        else n_pass++;
        enable = 0; ticks(3);
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10)
            $display("FAIL fault_held_enable0: fault=%b code=%b want 1 10", fault, fault_code);
        else n_pass++;
        fault_clr = 1; tick(); fault_clr = 0;
        n_checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00 || busy !== 1'b0)
            $display("FAIL dry_run_clear: fault=%b code=%b busy=%b want 0 00 0", fault, fault_code, busy);
        else n_pass++;
        I = 1; ticks(8);
        enable = 1;
    endtask

    task automatic test_sensor_fault();
        enable = 0; I = 0; S = 1; ticks(6);
        n_checks++;
        if (fault !== 1'b0) $display("FAIL sensor_fault_early: fault=%b want 0", fault);
        else n_pass++;
        tick();
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 2'b01)
            $display("FAIL sensor_fault: fault=%b code=%b want 1 01", fault, fault_code);
        else n_pass++;
        fault_clr = 1; tick(); fault_clr = 0; tick();
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 2'b01)
            $display("FAIL clr_ignored: fault=%b code=%b want 1 01", fault, fault_code);
        else n_pass++;
        S = 0; ticks(7);
        n_checks++;
        if (fault !== 1'b1) $display("FAIL fault_waits_clr: fault=%b want 1", fault);
        else n_pass++;
        fault_clr = 1; tick(); fault_clr = 0;
        n_checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00)
            $display("FAIL sensor_clear: fault=%b code=%b want 0 00", fault, fault_code);
        else n_pass++;
        I = 1; ticks(8);
        enable = 1;
    endtask

    task automatic test_enable_and_reset();
        I = 0; ticks(7);
        n_checks++;
        if (pump_a !== 1'b1) $display("FAIL fill_a: a=%b want 1", pump_a);
        else n_pass++;
        ticks(4);
        enable = 0; tick();
        n_checks++;
        if (pump_a !== 1'b0 || busy !== 1'b0) $display("FAIL enable_drop: a=%b busy=%b want 0 0", pump_a, busy);
        else n_pass++;
        enable = 1; tick();
        n_checks++;
        if (pump_b !== 1'b1 || pump_a !== 1'b0) $display("FAIL refill_b: a=%b b=%b want 0 1", pump_a, pump_b);
        else n_pass++;
        ticks(5);
        reset = 1; tick();
        n_checks++;
        if (pump_a !== 1'b0 || pump_b !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid_fill: a=%b b=%b busy=%b want 0 0 0", pump_a, pump_b, busy);
        else n_pass++;
        tick(); reset = 0;
        ticks(6);
        n_checks++;
        if (pump_a !== 1'b0 || pump_b !== 1'b0) $display("FAIL after_reset_pre: a=%b b=%b want 0 0", pump_a, pump_b);
        else n_pass++;
        tick();
        n_checks++;
        if (pump_a !== 1'b1 || pump_b !== 1'b0) $display("FAIL after_reset_a: a=%b b=%b want 1 0", pump_a, pump_b);
        else n_pass++;
        finish_fill();
    endtask

    task automatic test_random();
        int         hold_i, hold_s;
        logic [5:0] exp_v, act_v;
        hold_i = 0; hold_s = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_i == 0) begin
                I = $urandom_range(0, 1);
                hold_i = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
            end else hold_i--;
            if (hold_s == 0) begin
                S = $urandom_range(0, 1);
                hold_s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 90);
            end else hold_s--;
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            fault_clr = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
            exp_v = {m_filling && !m_pump, m_filling && m_pump, m_filling, m_faulted, m_code};
            act_v = {pump_a, pump_b, busy, fault, fault_code};
            n_checks++;
            if (act_v !== exp_v)
                $display("FAIL random cycle %0d {a,b,busy,fault,code}: got %b want %b", c, act_v, exp_v);
            else n_pass++;
        end
        reset = 0; fault_clr = 0;
    endtask

    initial begin
        test_reset();
        test_fill_alternate();
        test_glitch();
        test_min_run();
        test_dry_run();
        test_sensor_fault();
        test_enable_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
